// File: rtl/rtc_time_loader_pkg.sv
// Shared constants and types for the RP5C01 time loader: register map,
// mode nibbles, sequencer states and the BCD year re-basing helper.
package rtc_time_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR_REQ,
    ST_ADR_GAP,
    ST_DAT_REQ,
    ST_DAT_GAP
  } state_t;

  localparam logic [3:0] REG_SEC_LO   = 4'd0;
  localparam logic [3:0] REG_SEC_HI   = 4'd1;
  localparam logic [3:0] REG_MIN_LO   = 4'd2;
  localparam logic [3:0] REG_MIN_HI   = 4'd3;
  localparam logic [3:0] REG_HOUR_LO  = 4'd4;
  localparam logic [3:0] REG_HOUR_HI  = 4'd5;
  localparam logic [3:0] REG_WEEKDAY  = 4'd6;
  localparam logic [3:0] REG_DAY_LO   = 4'd7;
  localparam logic [3:0] REG_DAY_HI   = 4'd8;
  localparam logic [3:0] REG_MONTH_LO = 4'd9;
  localparam logic [3:0] REG_MONTH_HI = 4'd10;
  localparam logic [3:0] REG_YEAR_LO  = 4'd11;
  localparam logic [3:0] REG_YEAR_HI  = 4'd12;
  localparam logic [3:0] REG_MODE     = 4'd13;

  localparam logic [3:0] MODE_STOP = 4'h0;
  localparam logic [3:0] MODE_RUN  = 4'h8;

  localparam logic [3:0] LAST_INDEX = 4'd14;

  // RTC counts years from 1980, host supplies 20yy: add 20 in BCD, mod 100.
  function automatic logic [7:0] year_adjust(input logic [7:0] yy);
    logic [3:0] tens;
    tens = (yy[7:4] >= 4'd8) ? (yy[7:4] - 4'd8) : (yy[7:4] + 4'd2);
    return {tens, yy[3:0]};
  endfunction

endpackage

// File: rtl/rtc_time_loader_seq_rom.sv
// Combinational lookup from sequence index to the RTC register/nibble pair
// written at that step, drawn from the latched time snapshot.
module rtc_seq_rom
  import rtc_time_loader_pkg::*;
(
  input  logic [3:0]  index,
  input  logic [50:0] snapshot,
  output logic [3:0]  reg_sel,
  output logic [3:0]  value
);

  logic [7:0] year;

  always_comb begin
    year    = year_adjust(snapshot[47:40]);
    reg_sel = '0;
    value   = '0;
    unique case (index)
      4'd0:  begin reg_sel = REG_MODE;     value = MODE_STOP;             end
      4'd1:  begin reg_sel = REG_SEC_LO;   value = snapshot[3:0];         end
      4'd2:  begin reg_sel = REG_SEC_HI;   value = snapshot[7:4];         end
      4'd3:  begin reg_sel = REG_MIN_LO;   value = snapshot[11:8];        end
      4'd4:  begin reg_sel = REG_MIN_HI;   value = snapshot[15:12];       end
      4'd5:  begin reg_sel = REG_HOUR_LO;  value = snapshot[19:16];       end
      4'd6:  begin reg_sel = REG_HOUR_HI;  value = snapshot[23:20];       end
      4'd7:  begin reg_sel = REG_WEEKDAY;  value = {1'b0, snapshot[50:48]}; end
      4'd8:  begin reg_sel = REG_DAY_LO;   value = snapshot[27:24];       end
      4'd9:  begin reg_sel = REG_DAY_HI;   value = snapshot[31:28];       end
      4'd10: begin reg_sel = REG_MONTH_LO; value = snapshot[35:32];       end
      4'd11: begin reg_sel = REG_MONTH_HI; value = snapshot[39:36];       end
      4'd12: begin reg_sel = REG_YEAR_LO;  value = year[3:0];             end
      4'd13: begin reg_sel = REG_YEAR_HI;  value = year[7:4];             end
      4'd14: begin reg_sel = REG_MODE;     value = MODE_RUN;              end
      default: begin reg_sel = '0;         value = '0;                    end
    endcase
  end

endmodule

// File: rtl/rtc_time_loader.sv
// Loads host wall-clock time into the RP5C01 via address-port/data-port
// write pairs, after reset and on every host update toggle.
module rtc_time_loader
  import rtc_time_loader_pkg::*;
#(
  parameter logic [15:0] PORT_BASE   = 16'h00B4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic [64:0] rtc_time,
  output logic        req,
  output logic        wr,
  output logic [15:0] adr,
  output logic [7:0]  dbo,
  input  logic        ack,
  output logic        busy,
  output logic        error
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state, state_next;
  logic [3:0]    index;
  logic [50:0]   snapshot;
  logic          pending;
  logic          toggle_q;
  logic          toggle_edge;
  logic [CW-1:0] cnt;
  logic          start;
  logic          timeout;
  logic          in_req;
  logic [3:0]    rom_reg;
  logic [3:0]    rom_val;
  logic          unused_time;

  assign unused_time = ^rtc_time[63:51];
  assign toggle_edge = rtc_time[64] ^ toggle_q;
  assign in_req      = (state == ST_ADR_REQ) || (state == ST_DAT_REQ);
  assign wr          = req;

  rtc_seq_rom u_rom (
    .index    (index),
    .snapshot (snapshot),
    .reg_sel  (rom_reg),
    .value    (rom_val)
  );

  always_comb begin
    state_next = state;
    req        = 1'b0;
    adr        = '0;
    dbo        = '0;
    start      = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pending && ena) begin
          start      = 1'b1;
          state_next = ST_ADR_REQ;
        end
      end
      ST_ADR_REQ: begin
        req = 1'b1;
        adr = PORT_BASE;
        dbo = {4'h0, rom_reg};
        if (ack) begin
          state_next = ST_ADR_GAP;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ADR_GAP: state_next = ST_DAT_REQ;
      ST_DAT_REQ: begin
        req = 1'b1;
        adr = PORT_BASE + 16'd1;
        dbo = {4'h0, rom_val};
        if (ack) begin
          state_next = ST_DAT_GAP;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DAT_GAP: state_next = (index == LAST_INDEX) ? ST_IDLE : ST_ADR_REQ;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      index    <= '0;
      snapshot <= '0;
      pending  <= 1'b1;
      toggle_q <= rtc_time[64];
      error    <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      toggle_q <= rtc_time[64];

      // A toggle seen in the start cycle still counts, so it is never lost.
      if (start)
        pending <= toggle_edge;
      else if (toggle_edge)
        pending <= 1'b1;

      // REQ states are only entered from non-REQ states, so clearing the
      // counter outside them restarts the timeout window on every entry.
      cnt <= in_req ? cnt + 1'b1 : '0;

      if (start) begin
        snapshot <= rtc_time[50:0];
        error    <= 1'b0;
        busy     <= 1'b1;
        index    <= '0;
      end else if (timeout) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end else if (state == ST_DAT_GAP) begin
        if (index == LAST_INDEX)
          busy <= 1'b0;
        else
          index <= index + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_loader.sv
// Randomized scoreboard bench for rtc_time_loader with a bus responder and
// a monitor that checks every accepted write against the queued model.
module tb_rtc_time_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [64:0] rtc_time;
  logic        req, wr, busy, error, ack;
  logic [15:0] adr;
  logic [7:0]  dbo;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  int writes_seen = 0;
  int lat_max = 0;
  bit ack_hold = 1'b0;

  always #5 clk = ~clk;

  rtc_time_loader #(
    .PORT_BASE   (16'h00B4),
    .ACK_TIMEOUT (255)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .rtc_time (rtc_time),
    .req      (req),
    .wr       (wr),
    .adr      (adr),
    .dbo      (dbo),
    .ack      (ack),
    .busy     (busy),
    .error    (error)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [50:0] mk(input logic [7:0] s, m, h, d, mo, y, input logic [2:0] wd);
    return {wd, y, mo, d, h, m, s};
  endfunction

  function automatic logic [7:0] rand_bcd(input int max_tens);
    logic [3:0] t, o;
    t = 4'($urandom_range(max_tens, 0));
    o = 4'($urandom_range(9, 0));
    return {t, o};
  endfunction

  task automatic push_wr(input int r, input int v);
    exp_q.push_back({16'h00B4, 8'(r)});
    exp_q.push_back({16'h00B5, 8'(v)});
  endtask

  // Reference: field list in register order, year re-based by +20 mod 100.
  task automatic push_model(input logic [50:0] t);
    int reg_no;
    int yy;
    logic [7:0] f;
    push_wr(13, 0);
    reg_no = 0;
    for (int k = 0; k < 3; k++) begin
      f = t[8*k +: 8];
      push_wr(reg_no, f % 16); push_wr(reg_no + 1, f / 16);
      reg_no += 2;
    end
    push_wr(6, int'(t[50:48]));
    reg_no = 7;
    for (int k = 3; k < 5; k++) begin
      f = t[8*k +: 8];
      push_wr(reg_no, f % 16); push_wr(reg_no + 1, f / 16);
      reg_no += 2;
    end
    yy = int'(t[47:44]) * 10 + int'(t[43:40]);
    yy = (yy + 20) % 100;
    push_wr(11, yy % 10);
    push_wr(12, yy / 10);
    push_wr(13, 8);
  endtask

  // Bus responder: ack after a random number of wait cycles.
  initial begin : responder
    int lat_left;
    ack = 1'b0;
    lat_left = 0;
    forever begin
      @(posedge clk);
      #1;
      ack = 1'b0;
      if (reset) lat_left = 0;
      else if (req && !ack_hold) begin
        if (lat_left == 0) begin
          ack = 1'b1;
          lat_left = $urandom_range(lat_max, 0);
        end else lat_left--;
      end
    end
  end

  // Monitor: accepted writes, bus stability while req is high, 1-cycle gaps.
  initial begin : monitor
    logic prev_req, prev_busy;
    logic [23:0] prev_bus, e;
    int low_run;
    prev_req = 1'b0; prev_busy = 1'b0; prev_bus = '0; low_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0; prev_busy = 1'b0; low_run = 0;
      end else begin
        if (req) begin
          chk("wr_strobe", {31'b0, wr}, 1);
          if (prev_req) chk("bus_stable", {8'b0, adr, dbo}, {8'b0, prev_bus});
          else if (prev_busy) chk("gap_len", low_run, 1);
          if (ack) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_write: got %0h expected none", {adr, dbo});
            end else begin
              e = exp_q.pop_front();
              chk("write", {8'b0, adr, dbo}, {8'b0, e});
            end
          end
          low_run = 0;
        end else low_run++;
        prev_req = req; prev_bus = {adr, dbo}; prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_time(input logic [50:0] t, input bit flip);
    @(posedge clk); #1;
    rtc_time[50:0] = t;
    if (flip) rtc_time[64] = ~rtc_time[64];
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while ((busy || exp_q.size() != 0) && c < budget) begin
      @(negedge clk); c++;
    end
    chk(name, {31'b0, c < budget}, 1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (writes_seen < n && c < budget) begin
      @(negedge clk); c++;
    end
    chk("reach_index", {31'b0, c < budget}, 1);
  endtask

  logic [7:0] plan[30] = '{8'd13,8'd0, 8'd0,8'd5, 8'd1,8'd4, 8'd2,8'd0, 8'd3,8'd3,
                          8'd4,8'd3, 8'd5,8'd1, 8'd6,8'd3, 8'd7,8'd5, 8'd8,8'd2,
                          8'd9,8'd2, 8'd10,8'd1, 8'd11,8'd4, 8'd12,8'd4, 8'd13,8'd8};

  initial begin : stimulus
    logic [50:0] t, base;
    int c, w0;
    base = mk(8'h45, 8'h30, 8'h13, 8'h25, 8'h12, 8'h24, 3'd3);
    reset = 1'b1; ena = 1'b0;
    rtc_time = {1'b0, 13'b0, base};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_wr", {31'b0, wr}, 0);
    chk("rst_adr", {16'b0, adr}, 0);
    chk("rst_dbo", {24'b0, dbo}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_error", {31'b0, error}, 0);

    // Power-up load with zero-wait ack against the literal write list.
    for (int i = 0; i < 15; i++) push_wr(plan[2*i], plan[2*i+1]);
    @(posedge clk); #1; reset = 1'b0; ena = 1'b1;
    c = 0;
    while (!busy && c < 5) begin @(negedge clk); c++; end
    c = 0;
    while (busy && c < 200) begin @(negedge clk); c++; end
    chk("busy_cycles", c, 60);
    chk("powerup_drained", exp_q.size(), 0);
    chk("powerup_error", {31'b0, error}, 0);

    // Year wrap 85 -> 05.
    t = mk(8'h45, 8'h30, 8'h13, 8'h25, 8'h12, 8'h85, 3'd3);
    push_model(t);
    apply_time(t, 1'b1);
    wait_done("year_wrap_done", 200);

    // Three toggles while busy at index 5 collapse into one rerun.
    push_model(base);
    w0 = writes_seen;
    apply_time(base, 1'b1);
    wait_writes(w0 + 10, 100);
    t = mk(8'h46, 8'h30, 8'h13, 8'h25, 8'h12, 8'h24, 3'd3);
    push_model(t);
    repeat (3) apply_time(t, 1'b1);
    wait_done("rerun_done", 400);
    repeat (10) @(negedge clk);
    chk("single_rerun", {31'b0, busy}, 0);

    // Ack timeout, no automatic retry, then recovery on the next toggle.
    ack_hold = 1'b1;
    apply_time(base, 1'b1);
    c = 0;
    while (!req && c < 10) begin @(negedge clk); c++; end
    c = 0;
    while (req && c < 400) begin @(negedge clk); c++; end
    chk("timeout_len", c, 255);
    chk("timeout_error", {31'b0, error}, 1);
    chk("timeout_busy", {31'b0, busy}, 0);
    chk("timeout_req", {31'b0, req}, 0);
    repeat (20) @(negedge clk);
    chk("no_retry", {31'b0, busy}, 0);
    ack_hold = 1'b0;
    push_model(base);
    apply_time(base, 1'b1);
    c = 0;
    while (!busy && c < 5) begin @(negedge clk); c++; end
    chk("error_cleared", {31'b0, error}, 0);
    wait_done("recover_done", 200);

    // Random ack latency with random valid times.
    lat_max = 20;
    for (int n = 0; n < 3; n++) begin
      t = mk(rand_bcd(5), rand_bcd(5), rand_bcd(2), rand_bcd(2), rand_bcd(1),
             rand_bcd(9), 3'($urandom_range(6, 0)));
      push_model(t);
      apply_time(t, 1'b1);
      wait_done("random_done", 2000);
    end

    // Reset at index 9, held off by ena, restart once ena rises.
    lat_max = 3;
    push_model(base);
    w0 = writes_seen;
    apply_time(base, 1'b1);
    wait_writes(w0 + 18, 300);
    @(posedge clk); #1; reset = 1'b1; ena = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("req_after_reset", {31'b0, req}, 0);
    @(posedge clk); #1; reset = 1'b0;
    rtc_time[50:0] = mk(8'h07, 8'h59, 8'h23, 8'h31, 8'h01, 8'h99, 3'd6);
    c = 0;
    repeat (30) begin @(negedge clk); if (req || busy) c++; end
    chk("ena_gate", c, 0);
    push_model(rtc_time[50:0]);
    @(posedge clk); #1; ena = 1'b1;
    @(negedge clk);
    chk("start_wait", {31'b0, req}, 0);
    @(negedge clk);
    chk("start_after_ena", {31'b0, req}, 1);
    wait_done("post_reset_done", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_time_loader.md
Name: rtc_time_loader

Overview:
- Bus initiator that loads the host-supplied wall-clock time (`rtc_time`) into the RP5C01 RTC device.
- It does this through the RTC's two-port I/O protocol: a register-select write to the address port, then a nibble write to the data port.
- It runs after reset and on every host time-update toggle.
- It sits beside the CPU bus in the peripheral tree. The top level muxes its request channel onto the RTC device's `req/wr/adr/dbo` inputs while `busy` is high.

Parameters:
- PORT_BASE, 16'h00B4, I/O address of the RTC address port; the data port is PORT_BASE+1.
- ACK_TIMEOUT, 255, maximum cycles `req` may stay high waiting for `ack` before abort.

Ports:
- clk  input  1  system clock (cpu_bus.clk domain).
- reset  input  1  synchronous, active-high reset.
- ena  input  1  RTC device enabled; triggers are held pending while low.
- rtc_time  input  65  host time, BCD. [7:0] sec, [15:8] min, [23:16] hour, [31:24] day, [39:32] month, [47:40] year (20yy), [50:48] weekday 0-6, [64] update toggle.
- req  output  1  transaction request.
- wr  output  1  write strobe; equals `req`.
- adr  output  16  port address.
- dbo  output  8  write data; upper nibble always 0.
- ack  input  1  one-cycle completion pulse from the RTC.
- busy  output  1  sequence in progress.
- error  output  1  sticky ack timeout; cleared only by reset or by the start of the next sequence.

Behaviour:
- Reset values: req=0, wr=0, adr=0, dbo=0, busy=0, error=0. FSM=IDLE, pending=1, toggle register = rtc_time[64].
- Trigger sources: pending set by reset, and any cycle where rtc_time[64] differs from its registered copy.
- Start condition: in IDLE with pending=1 and ena=1. On start:
  - snapshot rtc_time[50:0];
  - clear pending and error;
  - index=0, busy=1;
  - go to ADR_REQ.
- FSM states: IDLE, ADR_REQ, ADR_GAP, DAT_REQ, DAT_GAP.
  - ADR_REQ: req=1, adr=PORT_BASE, dbo=reg(index). On ack go to ADR_GAP.
  - ADR_GAP: req=0 for exactly one cycle, then DAT_REQ.
  - DAT_REQ: req=1, adr=PORT_BASE+1, dbo=val(index). On ack go to DAT_GAP.
  - DAT_GAP: req=0 for one cycle. If index=14, go to IDLE with busy=0; otherwise index+1 and go to ADR_REQ.
- Handshake rules:
  - `adr`/`dbo` are stable for the whole time `req` is high.
  - `ack` arriving in the same cycle `req` first rises is accepted.
  - `ack` outside the REQ states is ignored.
  - Minimum cost is 2 cycles per port write and 4 per register; 60 cycles per full sequence with zero-wait ack.
- Sequence table (index: reg <= value):
  - 0: 13 <= 0x0 (block 0, timer stop).
  - 1: 0 <= sec lo. 2: 1 <= sec hi.
  - 3: 2 <= min lo. 4: 3 <= min hi.
  - 5: 4 <= hour lo. 6: 5 <= hour hi.
  - 7: 6 <= weekday.
  - 8: 7 <= day lo. 9: 8 <= day hi.
  - 10: 9 <= month lo. 11: 10 <= month hi.
  - 12: 11 <= year lo. 13: 12 <= year hi.
  - 14: 13 <= 0x8 (timer enable, block 0).
- Year conversion: the RTC counts years since 1980, so the year value is BCD yy+20 mod 100.
  - Low digit unchanged.
  - High digit = (tens+2) mod 10.
  - Example: 0x24 -> 0x44; 0x85 -> 0x05.
- Not written: the 12/24 select register (block 1 reg 10); RTC setup owns it.
- Toggle during busy: set pending; snapshot unchanged. After DAT_GAP of index 14, start again next cycle with a fresh snapshot. Multiple toggles during one sequence collapse into exactly one rerun.
- Timeout: a counter resets on entry to each REQ state. If it reaches ACK_TIMEOUT without ack:
  - req=0, error=1, busy=0, FSM=IDLE;
  - pending is left unchanged; no automatic retry until the next toggle.
- Reset mid-sequence: req drops in the reset cycle, the snapshot is discarded, and a full sequence restarts with fresh rtc_time.
- ena dropping mid-sequence: the current sequence completes; ena gates only the start of a sequence.

Decomposition:
- Shared package entries:
  - RTC register index constants (REG_MODE=13, REG_SEC_LO..REG_YEAR_HI);
  - mode values MODE_STOP=4'h0, MODE_RUN=4'h8;
  - FSM state enum typedef.
- Sub-module: rtc_seq_rom (combinational index -> {reg, value} lookup including the year BCD adjust). Everything else stays in one module.

Test Plan:
- Power-up load: reset, then rtc_time sec=0x45 min=0x30 hour=0x13 day=0x25 month=0x12 year=0x24 wd=3, zero-wait ack. Expect 30 writes alternating 0xB4/0xB5: (13,0)(0,5)(1,4)(2,0)(3,3)(4,3)(5,1)(6,3)(7,5)(8,2)(9,2)(10,1)(11,4)(12,4)(13,8). busy high for 60 cycles, then 0.
- Year wrap: year=0x85, other fields as above. Expect reg 11 <= 5 and reg 12 <= 0.
- Toggle during busy: flip rtc_time[64] three times at index 5 with sec changed to 0x46. Expect exactly one rerun immediately after; its reg 0 <= 6.
- Timeout: ack held 0. Expect req high for 255 cycles, then req=0, error=1, busy=0; the next toggle runs normally and clears error.
- Random ack latency 0-20 cycles: expect adr/dbo stable while req is high, req low exactly one cycle between writes, and the correct table order.
- Reset at index 9 with ena low afterwards: expect req=0 the cycle after reset, no writes while ena=0, and a full sequence starting one cycle after ena rises.
